// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the register file: pipeline writeback always wins, the aux
// unit takes idle cycles, with a busy scoreboard, starvation stall and sticky error flag.
module regfile_wb_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int XLEN         = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pipe_wr_i,
   input  logic [4:0]      pipe_addr_i,
   input  logic [XLEN-1:0] pipe_data_i,
   input  logic            aux_valid_i,
   output logic            aux_ready_o,
   input  logic [4:0]      aux_addr_i,
   input  logic [XLEN-1:0] aux_data_i,
   input  logic            aux_issue_i,
   input  logic [4:0]      aux_issue_rd_i,
   input  logic [4:0]      rs1_i,
   input  logic [4:0]      rs2_i,
   input  logic [4:0]      rd_i,
   output logic            hazard_o,
   output logic            stall_o,
   output logic            rf_write_o,
   output logic [4:0]      rf_wrAddr_o,
   output logic [XLEN-1:0] rf_wrData_o,
   output logic [31:0]     busy_o,
   output logic            err_o
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_TRIG = CNT_W'(STARVE_LIMIT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);

   logic [31:0]      busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stall_q, stall_d;
   logic             err_q, err_d;

   logic pipe_act;
   logic aux_hs;
   logic aux_blocked;
   logic sb_set;
   logic sb_clr;
   logic same_reg;

   // Grant: the pipeline is never delayed; aux only sees the port on pipe-idle cycles.
   assign pipe_act    = pipe_wr_i & (pipe_addr_i != 5'd0);
   assign aux_ready_o = rst_n & ~pipe_act;
   assign aux_hs      = aux_valid_i & aux_ready_o;
   assign aux_blocked = aux_valid_i & ~aux_ready_o;

   assign rf_write_o  = rst_n & (pipe_act | (aux_hs & (aux_addr_i != 5'd0)));
   assign rf_wrAddr_o = pipe_act ? pipe_addr_i : aux_addr_i;
   assign rf_wrData_o = pipe_act ? pipe_data_i : aux_data_i;

   assign sb_set   = aux_issue_i & (aux_issue_rd_i != 5'd0);
   assign sb_clr   = aux_hs & (aux_addr_i != 5'd0);
   assign same_reg = sb_clr & (aux_addr_i == aux_issue_rd_i);

   assign hazard_o = busy_q[rs1_i] | busy_q[rs2_i] | busy_q[rd_i];
   assign busy_o   = busy_q;
   assign stall_o  = stall_q;
   assign err_o    = err_q;

   always_comb begin
      busy_d = busy_q;
      if (sb_clr) begin
         busy_d[aux_addr_i] = 1'b0;
      end
      // Set after clear so a same-edge reissue keeps the register busy.
      if (sb_set) begin
         busy_d[aux_issue_rd_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      cnt_d   = cnt_q;
      stall_d = stall_q;
      if (!aux_valid_i || aux_hs) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
      if (aux_hs) begin
         stall_d = 1'b0;
      end else if (aux_blocked && (cnt_q >= CNT_TRIG)) begin
         stall_d = 1'b1;
      end
   end

   always_comb begin
      err_d = err_q;
      if (sb_set && busy_q[aux_issue_rd_i] && !same_reg) begin
         err_d = 1'b1;
      end
      if (sb_clr && !busy_q[aux_addr_i]) begin
         err_d = 1'b1;
      end
      if (pipe_act && stall_q) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= '0;
         cnt_q   <= '0;
         stall_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: grant priority, scoreboard, starvation stall
// and error flag, each scenario checked against hand-computed values.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pipe_wr_i;
   logic [4:0]  pipe_addr_i;
   logic [31:0] pipe_data_i;
   logic        aux_valid_i;
   logic        aux_ready_o;
   logic [4:0]  aux_addr_i;
   logic [31:0] aux_data_i;
   logic        aux_issue_i;
   logic [4:0]  aux_issue_rd_i;
   logic [4:0]  rs1_i, rs2_i, rd_i;
   logic        hazard_o, stall_o, rf_write_o, err_o;
   logic [4:0]  rf_wrAddr_o;
   logic [31:0] rf_wrData_o;
   logic [31:0] busy_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.STARVE_LIMIT(4), .XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .pipe_wr_i(pipe_wr_i), .pipe_addr_i(pipe_addr_i), .pipe_data_i(pipe_data_i),
      .aux_valid_i(aux_valid_i), .aux_ready_o(aux_ready_o), .aux_addr_i(aux_addr_i),
      .aux_data_i(aux_data_i), .aux_issue_i(aux_issue_i), .aux_issue_rd_i(aux_issue_rd_i),
      .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .hazard_o(hazard_o), .stall_o(stall_o),
      .rf_write_o(rf_write_o), .rf_wrAddr_o(rf_wrAddr_o), .rf_wrData_o(rf_wrData_o),
      .busy_o(busy_o), .err_o(err_o)
   );

   task automatic idle();
      pipe_wr_i = 0; pipe_addr_i = 0; pipe_data_i = 0;
      aux_valid_i = 0; aux_addr_i = 0; aux_data_i = 0;
      aux_issue_i = 0; aux_issue_rd_i = 0;
      rs1_i = 0; rs2_i = 0; rd_i = 0;
   endtask

   task automatic issue(input logic [4:0] rd);
      @(negedge clk); idle(); aux_issue_i = 1; aux_issue_rd_i = rd;
   endtask

   task automatic test_reset();
      idle();
      rst_n = 0; aux_valid_i = 1; aux_addr_i = 5'd7; pipe_wr_i = 1; pipe_addr_i = 5'd5;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (rf_write_o !== 1'b0) begin errors++; $display("FAIL reset_rf_write got=%b exp=0", rf_write_o); end
      checks++; if (aux_ready_o !== 1'b0) begin errors++; $display("FAIL reset_aux_ready got=%b exp=0", aux_ready_o); end
      checks++; if (busy_o !== 32'h0) begin errors++; $display("FAIL reset_busy got=%h exp=0", busy_o); end
      checks++; if (stall_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL reset_stall_err got=%b%b exp=00", stall_o, err_o); end
      idle(); rst_n = 1;
   endtask

   task automatic test_grant();
      issue(5'd7);
      @(negedge clk); idle();
      pipe_wr_i = 1; pipe_addr_i = 5'd5; pipe_data_i = 32'hA5;
      aux_valid_i = 1; aux_addr_i = 5'd7; aux_data_i = 32'h1234;
      #1;
      checks++; if ({rf_write_o, rf_wrAddr_o, rf_wrData_o} !== {1'b1, 5'd5, 32'hA5}) begin
         errors++; $display("FAIL grant_pipe got=%b/%0d/%h exp=1/5/a5", rf_write_o, rf_wrAddr_o, rf_wrData_o); end
      checks++; if (aux_ready_o !== 1'b0) begin errors++; $display("FAIL grant_aux_blocked got=%b exp=0", aux_ready_o); end
      @(negedge clk); pipe_wr_i = 0; #1;
      checks++; if ({rf_write_o, rf_wrAddr_o, rf_wrData_o, aux_ready_o} !== {1'b1, 5'd7, 32'h1234, 1'b1}) begin
         errors++; $display("FAIL grant_aux got=%b/%0d/%h rdy=%b exp=1/7/1234 rdy=1", rf_write_o, rf_wrAddr_o, rf_wrData_o, aux_ready_o); end
      @(negedge clk); idle(); pipe_wr_i = 1; pipe_addr_i = 5'd0; pipe_data_i = 32'hFF; #1;
      checks++; if (rf_write_o !== 1'b0 || aux_ready_o !== 1'b1) begin
         errors++; $display("FAIL grant_x0 got=wr%b rdy%b exp=wr0 rdy1", rf_write_o, aux_ready_o); end
      checks++; if (busy_o !== 32'h0 || err_o !== 1'b0) begin
         errors++; $display("FAIL grant_after busy=%h err=%b exp=0/0", busy_o, err_o); end
      idle();
   endtask

   task automatic test_scoreboard();
      issue(5'd9);
      @(negedge clk); idle(); rs1_i = 5'd9; #1;
      checks++; if (busy_o !== 32'h0000_0200) begin errors++; $display("FAIL sb_set got=%h exp=00000200", busy_o); end
      checks++; if (hazard_o !== 1'b1) begin errors++; $display("FAIL sb_hazard got=%b exp=1", hazard_o); end
      rs1_i = 5'd0; rd_i = 5'd8; #1;
      checks++; if (hazard_o !== 1'b0) begin errors++; $display("FAIL sb_no_hazard got=%b exp=0", hazard_o); end
      rs2_i = 5'd9; aux_valid_i = 1; aux_addr_i = 5'd9; aux_data_i = 32'h99; #1;
      checks++; if (hazard_o !== 1'b1 || rf_write_o !== 1'b1) begin
         errors++; $display("FAIL sb_hs_cycle got=haz%b wr%b exp=haz1 wr1", hazard_o, rf_write_o); end
      @(negedge clk); aux_valid_i = 0; #1;
      checks++; if (hazard_o !== 1'b0 || busy_o !== 32'h0) begin
         errors++; $display("FAIL sb_clear got=haz%b busy=%h exp=haz0 busy=0", hazard_o, busy_o); end
      idle();
   endtask

   task automatic test_starve();
      issue(5'd12);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); idle();
         pipe_wr_i = 1; pipe_addr_i = 5'(i + 1); pipe_data_i = 32'(i);
         aux_valid_i = 1; aux_addr_i = 5'd12; aux_data_i = 32'hC0C0; #1;
         checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL starve_early_%0d got=%b exp=0", i, stall_o); end
      end
      @(negedge clk); pipe_wr_i = 0; pipe_addr_i = 0; #1;
      checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL starve_stall got=%b exp=1", stall_o); end
      checks++; if (aux_ready_o !== 1'b1 || rf_wrAddr_o !== 5'd12) begin
         errors++; $display("FAIL starve_grant got=rdy%b addr%0d exp=rdy1 addr12", aux_ready_o, rf_wrAddr_o); end
      @(negedge clk); idle(); #1;
      checks++; if (stall_o !== 1'b0 || err_o !== 1'b0 || busy_o !== 32'h0) begin
         errors++; $display("FAIL starve_release got=st%b err%b busy%h exp=st0 err0 busy0", stall_o, err_o, busy_o); end
   endtask

   task automatic test_same_edge();
      issue(5'd4);
      @(negedge clk); idle();
      aux_valid_i = 1; aux_addr_i = 5'd4; aux_issue_i = 1; aux_issue_rd_i = 5'd4;
      @(negedge clk); idle(); #1;
      checks++; if (busy_o !== 32'h0000_0010 || err_o !== 1'b0) begin
         errors++; $display("FAIL same_edge got=busy%h err%b exp=busy00000010 err0", busy_o, err_o); end
      aux_valid_i = 1; aux_addr_i = 5'd4;
      @(negedge clk); idle(); #1;
      checks++; if (busy_o !== 32'h0) begin errors++; $display("FAIL same_edge_done got=%h exp=0", busy_o); end
   endtask

   task automatic test_err();
      issue(5'd3);
      issue(5'd3);
      @(negedge clk); idle(); #1;
      checks++; if (err_o !== 1'b1 || busy_o !== 32'h0000_0008) begin
         errors++; $display("FAIL err_double got=err%b busy%h exp=err1 busy00000008", err_o, busy_o); end
      issue(5'd0);
      @(negedge clk); idle(); #1;
      checks++; if (err_o !== 1'b1 || busy_o !== 32'h0000_0008) begin
         errors++; $display("FAIL err_x0_sticky got=err%b busy%h exp=err1 busy00000008", err_o, busy_o); end
      #2 rst_n = 0; #1;
      checks++; if (err_o !== 1'b0 || busy_o !== 32'h0) begin
         errors++; $display("FAIL err_async_reset got=err%b busy%h exp=err0 busy0", err_o, busy_o); end
      @(negedge clk); rst_n = 1;
   endtask

   initial begin
      test_reset();
      test_grant();
      test_scoreboard();
      test_starve();
      test_same_edge();
      test_err();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
